// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential 5-digit packed BCD to 17-bit binary converter.
// Reverse double-dabble, one shift/correct iteration per clock, 21-clock latency.
// Optional build macro BCD2BIN_CHECK_EN adds the err output and invalid-digit
// screening; without it the datapath runs unchanged on any nibble value.
module bcd_to_bin_seq (
  input  logic        clk_10kHz,
  input  logic        clr,
  input  logic        start,
  input  logic [19:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] bin
`ifdef BCD2BIN_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  // {bcd[19:0], acc[19:0]} working register
  logic [39:0] sr_q;
  logic [39:0] sr_d;
  logic [39:0] sr_shift_s;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [16:0] bin_q;
`ifdef BCD2BIN_CHECK_EN
  logic        inv_q;
  logic        err_q;
  logic        inv_s;
`endif

  // A BCD digit that reached >= 8 after the right shift carried in a
  // half-weight of 5 from the digit above; subtracting 3 restores it.
  function automatic logic [3:0] fix_nibble(input logic [3:0] n);
    if (n >= 4'd8) begin
      return n - 4'd3;
    end else begin
      return n;
    end
  endfunction

`ifdef BCD2BIN_CHECK_EN
  // True when any of the five packed digits is outside 0..9.
  function automatic logic any_bad_digit(input logic [19:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Screen the incoming operand for illegal digits.
  always_comb begin
    inv_s = any_bad_digit(bcd_in);
  end
`endif

  // One iteration: shift the whole register right, then correct each BCD nibble.
  always_comb begin
    sr_shift_s = sr_q >> 6'd1;
    sr_d       = sr_shift_s;
    for (int i = 0; i < 5; i++) begin
      sr_d[20 + 4*i +: 4] = fix_nibble(sr_shift_s[20 + 4*i +: 4]);
    end
  end

  // Control FSM with registered outputs; clr wins over every state.
  always_ff @(posedge clk_10kHz) begin
    if (clr) begin
      state_q <= IDLE;
      sr_q    <= 40'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= 17'd0;
`ifdef BCD2BIN_CHECK_EN
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q    <= {bcd_in, 20'd0};
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= CONV;
`ifdef BCD2BIN_CHECK_EN
            inv_q   <= inv_s;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 5'd1;
          // The 20th iteration is the one performed while cnt_q is 19.
          if (cnt_q == 5'd19) begin
            state_q <= DONE;
          end else begin
            state_q <= CONV;
          end
        end
        DONE: begin
`ifdef BCD2BIN_CHECK_EN
          bin_q <= inv_q ? 17'd0 : sr_q[16:0];
          err_q <= inv_q;
`else
          bin_q <= sr_q[16:0];
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
`ifdef BCD2BIN_CHECK_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: scoreboard of decimal-model results,
// latency, busy/done framing, bin hold, start-while-busy, clr abort, bad digits.
// Build with or without BCD2BIN_CHECK_EN.
module tb_bcd_to_bin_seq;

  logic        clk_10kHz = 1'b0;
  logic        clr;
  logic        start;
  logic [19:0] bcd_in;
  logic        busy;
  logic        done;
  logic [16:0] bin;
`ifdef BCD2BIN_CHECK_EN
  logic        err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Scoreboard entry: {compare_bin, err, bin}
  logic [18:0] sb_q[$];
  logic [16:0] held_bin;
  bit          held_known;

  always #5 clk_10kHz = ~clk_10kHz;

  bcd_to_bin_seq dut (
    .clk_10kHz(clk_10kHz),
    .clr      (clr),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .bin      (bin)
`ifdef BCD2BIN_CHECK_EN
    ,
    .err      (err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: weight each digit by its power of ten.
  function automatic logic [18:0] model(input logic [19:0] b);
    int         v;
    bit         bad;
    logic [3:0] d;
    logic [31:0] vv;
    v   = 0;
    bad = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      v = v * 10 + int'(d);
    end
    vv = v;
`ifdef BCD2BIN_CHECK_EN
    if (bad) return {1'b1, 1'b1, 17'd0};
`else
    if (bad) return {1'b0, 1'b0, 17'd0};
`endif
    return {1'b1, 1'b0, vv[16:0]};
  endfunction

  // Run one conversion; optionally pulse a second start before edge ign_at.
  task automatic conv(input logic [19:0] b, input int ign_at, input logic [19:0] ign_b);
    int          lat;
    logic [18:0] e;
    start  = 1'b1;
    bcd_in = b;
    sb_q.push_back(model(b));
    @(posedge clk_10kHz); #1;
    start  = 1'b0;
    bcd_in = 20'($urandom);
    check_eq("busy_accept", {31'd0, busy}, 32'd1);
    check_eq("done_low_accept", {31'd0, done}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == ign_at) begin
        start  = 1'b1;
        bcd_in = ign_b;
      end
      @(posedge clk_10kHz); #1;
      start  = 1'b0;
      bcd_in = 20'($urandom);
      if (done) begin
        lat = k;
        break;
      end
      check_eq("busy_conv", {31'd0, busy}, 32'd1);
      if (held_known) check_eq("bin_hold", {15'd0, bin}, {15'd0, held_bin});
    end
    check_eq("latency", lat, 32'd21);
    check_eq("busy_after_done", {31'd0, busy}, 32'd0);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e[18]) begin
        check_eq("bin", {15'd0, bin}, {15'd0, e[16:0]});
        held_bin   = e[16:0];
        held_known = 1'b1;
      end else begin
        held_known = 1'b0;
      end
`ifdef BCD2BIN_CHECK_EN
      check_eq("err", {31'd0, err}, {31'd0, e[17]});
`endif
    end
  endtask

  // Start a conversion and kill it with clr sampled at edge 10.
  task automatic abort_conv(input logic [19:0] b);
    int pulses;
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk_10kHz); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_10kHz); #1;
    end
    clr = 1'b1;
    @(posedge clk_10kHz); #1;
    clr = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_bin", {15'd0, bin}, 32'd0);
`ifdef BCD2BIN_CHECK_EN
    check_eq("abort_err", {31'd0, err}, 32'd0);
`endif
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_10kHz); #1;
      if (done) pulses++;
    end
    check_eq("abort_no_done", pulses, 32'd0);
    held_bin   = 17'd0;
    held_known = 1'b1;
  endtask

  initial begin
    logic [19:0] r;
    clr    = 1'b1;
    start  = 1'b0;
    bcd_in = 20'd0;
    held_bin   = 17'd0;
    held_known = 1'b1;
    repeat (3) @(posedge clk_10kHz);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_bin", {15'd0, bin}, 32'd0);
`ifdef BCD2BIN_CHECK_EN
    check_eq("rst_err", {31'd0, err}, 32'd0);
`endif
    clr = 1'b0;

    conv(20'h00000, 0, 20'h0);
    conv(20'h02794, 0, 20'h0);
    conv(20'h65535, 0, 20'h0);
    conv(20'h99999, 0, 20'h0);
    conv(20'h00007, 5, 20'h00010);
    conv(20'h00010, 0, 20'h0);
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'($urandom_range(9));
      conv(r, 0, 20'h0);
    end
    abort_conv(20'h12345);
    conv(20'h00001, 0, 20'h0);
    conv(20'h1A000, 0, 20'h0);
    conv(20'h00042, 0, 20'h0);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
